// File: rtl/move_scheduler.sv
// move_scheduler: merges SPI move bytes and gravity ticks into a single
// valid/ready command stream for game_executioner, in the HSOSC clock domain.
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   spi_data, spi_data_valid        byte from the spi block and its level flag
//   spi_clear                       one-cycle pulse: byte consumed
//   level, pause                    gravity speed level, freeze gravity and issue
//   cmd_move, cmd_piece             command payload
//   cmd_gravity, cmd_valid          payload is a drop, command presented
//   cmd_ready                       executioner handshake
//   fifo_count, overflow            move FIFO occupancy, sticky drop flag
module move_scheduler #(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned DROP_PERIOD = 48_000_000,
    parameter int unsigned MIN_PERIOD  = 1_500_000,
    parameter logic [1:0]  DROP_CMD    = 2'd2,
    parameter int unsigned CNT_WIDTH   = 26
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    spi_data,
    input  logic                          spi_data_valid,
    output logic                          spi_clear,
    input  logic [3:0]                    level,
    input  logic                          pause,
    output logic [1:0]                    cmd_move,
    output logic [2:0]                    cmd_piece,
    output logic                          cmd_gravity,
    output logic                          cmd_valid,
    input  logic                          cmd_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] CNT_ONE = (AW+1)'(1);
    localparam logic [CNT_WIDTH-1:0] DROP_W = CNT_WIDTH'(DROP_PERIOD);
    localparam logic [CNT_WIDTH-1:0] MIN_W = CNT_WIDTH'(MIN_PERIOD);
    localparam logic [CNT_WIDTH-1:0] GRAV_ONE = CNT_WIDTH'(1);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t state;

    logic                 spi_valid_q;
    logic [5:0]           cap_byte;
    logic [4:0]           fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [CNT_WIDTH-1:0] grav_cnt;
    logic                 grav_pending;
    logic                 last_grav;

    logic [CNT_WIDTH-1:0] shifted;
    logic [CNT_WIDTH-1:0] period_m1;
    logic                 full;
    logic                 accept;
    logic                 pop;
    logic                 push;
    logic                 push_ok;
    logic                 tick;
    logic                 move_pend;
    logic                 pick_grav;
    logic                 unused_bits;

    assign unused_bits = ^spi_data[7:6];

    always_comb begin
        shifted   = DROP_W >> level;
        period_m1 = ((shifted > MIN_W) ? shifted : MIN_W) - GRAV_ONE;
        full      = (fifo_count == FULL_CNT);
        accept    = cmd_valid & cmd_ready;
        pop       = accept & ~cmd_gravity;
        // Captured byte is pushed on the same cycle spi_clear is high.
        push      = spi_clear & cap_byte[5];
        push_ok   = push & (~full | pop);
        // >= rather than == so a shorter period after a level bump
        // fires immediately instead of waiting for a wrap.
        tick      = ~pause & (grav_cnt >= period_m1);
        move_pend = (fifo_count != '0);
        // Round-robin: gravity wins a tie only if a move went last.
        pick_grav = grav_pending & (~move_pend | ~last_grav);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            spi_valid_q <= 1'b0;
            spi_clear   <= 1'b0;
            cap_byte    <= '0;
        end else begin
            spi_valid_q <= spi_data_valid;
            spi_clear   <= spi_data_valid & ~spi_valid_q;
            if (spi_data_valid & ~spi_valid_q) begin
                cap_byte <= spi_data[5:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= cap_byte[4:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   fifo_count <= fifo_count + CNT_ONE;
                2'b01:   fifo_count <= fifo_count - CNT_ONE;
                default: fifo_count <= fifo_count;
            endcase
            if (push & ~push_ok) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grav_cnt     <= '0;
            grav_pending <= 1'b0;
        end else begin
            if (!pause) begin
                grav_cnt <= (grav_cnt >= period_m1) ? '0 : grav_cnt + GRAV_ONE;
            end
            if (accept & cmd_gravity) begin
                grav_pending <= 1'b0;
            end
            if (tick) begin
                grav_pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            last_grav   <= 1'b1;
            cmd_valid   <= 1'b0;
            cmd_move    <= '0;
            cmd_piece   <= '0;
            cmd_gravity <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!pause && (grav_pending || move_pend)) begin
                        cmd_valid   <= 1'b1;
                        cmd_gravity <= pick_grav;
                        cmd_move    <= pick_grav ? DROP_CMD : fifo_mem[rd_ptr][1:0];
                        cmd_piece   <= pick_grav ? 3'd0 : fifo_mem[rd_ptr][4:2];
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        last_grav <= cmd_gravity;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
